// File: rtl/rns_rev_2011_2048_pkg.sv
// ---------------------------------------------------------------------------
// rns_rev_2011_2048_pkg
// Shared constants and types for the {2011, 2048} residue-to-binary converter.
//   M           : odd modulus 2011
//   M_INV_2048  : multiplicative inverse of 2048 modulo 2011 (924)
//   RES_W       : residue width (11 bits)
//   X_W         : reconstructed value width (22 bits)
//   CNT_W       : width of the MUL bit counter
//   state_t     : converter FSM states
//   reduce_once : single conditional subtract of M (maps 2011..2047 back)
// ---------------------------------------------------------------------------
package rns_rev_2011_2048_pkg;

    localparam int RES_W = 11;
    localparam int X_W   = 22;
    localparam int CNT_W = 4;

    localparam logic [RES_W-1:0] M          = 11'd2011;
    localparam logic [RES_W-1:0] M_INV_2048 = 11'd924;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // An 11-bit value is < 2*M, so one subtract always yields a canonical residue.
    function automatic logic [RES_W-1:0] reduce_once(input logic [RES_W-1:0] r);
        logic [RES_W-1:0] res;
        res = (r >= M) ? (r - M) : r;
        return res;
    endfunction

endpackage

// File: rtl/rns_rev_2011_2048_mod_2011_dbl_add.sv
// ---------------------------------------------------------------------------
// mod_2011_dbl_add
// One MSB-first step of the modular shift-and-add multiplier:
//   acc_next = (2*acc mod 2011) [+ d, mod 2011 if mul_bit]
// Ports:
//   acc      in  [10:0] current accumulator (canonical, < 2011)
//   d        in  [10:0] multiplicand (canonical, < 2011)
//   mul_bit  in         current multiplier bit
//   acc_next out [10:0] updated accumulator (canonical)
// ---------------------------------------------------------------------------
module mod_2011_dbl_add
    import rns_rev_2011_2048_pkg::*;
(
    input  logic [RES_W-1:0] acc,
    input  logic [RES_W-1:0] d,
    input  logic             mul_bit,
    output logic [RES_W-1:0] acc_next
);

    logic [RES_W:0] dbl;
    logic [RES_W:0] dbl_red;
    logic [RES_W:0] sum;
    logic [RES_W:0] sum_red;

    // Both operands are < M, so 2*acc and dbl_red + d are each < 2*M and a
    // single conditional subtract brings them back into range.
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= {1'b0, M}) ? (dbl - {1'b0, M}) : dbl;
        sum     = dbl_red + {1'b0, d};
        sum_red = dbl_red;
        if (mul_bit) begin
            sum_red = (sum >= {1'b0, M}) ? (sum - {1'b0, M}) : sum;
        end
        acc_next = sum_red[RES_W-1:0];
    end

endmodule

// File: rtl/rns_rev_2011_2048.sv
// ---------------------------------------------------------------------------
// rns_rev_2011_2048
// Residue-number-system reverse converter for moduli {2011, 2048} using CRT:
//   t = ((R1c - R2c) * 924) mod 2011,  X = {t, R2}
// One operation in flight; fixed latency of 12 edges from acceptance to
// out_valid.
// Ports:
//   clk       in        rising-edge clock
//   rst_n     in        asynchronous active-low reset
//   in_valid  in        residue pair present
//   in_ready  out       converter idle and able to accept
//   R1        in [11:1] residue mod 2011 (2011..2047 accepted, reduced once)
//   R2        in [11:1] residue mod 2048
//   out_valid out       X holds a result
//   out_ready in        consumer accepts X
//   X         out[22:1] reconstructed value, 0 <= X < 4118528
// ---------------------------------------------------------------------------
module rns_rev_2011_2048
    import rns_rev_2011_2048_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [11:1]   R1,
    input  logic [11:1]   R2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [22:1]   X
);

    state_t             state_reg, state_next;
    logic [RES_W-1:0]   r1_reg,  r1_next;
    logic [RES_W-1:0]   r2_reg,  r2_next;
    logic [RES_W-1:0]   d_reg,   d_next;
    logic [RES_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [X_W-1:0]     x_reg,   x_next;

    logic [RES_W-1:0]   r1c;
    logic [RES_W-1:0]   r2c;
    logic [RES_W:0]     diff;
    logic [RES_W-1:0]   d_prep;
    logic [RES_W-1:0]   step_acc;
    logic               mul_bit;
    logic [RES_W-1:0]   inv_const;

    // Difference of canonical residues; on borrow the low 11 bits hold
    // 2048 + (r1c - r2c), and adding M wraps mod 2048 to r1c - r2c + 2011.
    always_comb begin
        r1c       = reduce_once(r1_reg);
        r2c       = reduce_once(r2_reg);
        diff      = {1'b0, r1c} - {1'b0, r2c};
        d_prep    = diff[RES_W] ? (diff[RES_W-1:0] + M) : diff[RES_W-1:0];
        inv_const = M_INV_2048;
        mul_bit   = inv_const[cnt_reg];
    end

    mod_2011_dbl_add u_step (
        .acc      (acc_reg),
        .d        (d_reg),
        .mul_bit  (mul_bit),
        .acc_next (step_acc)
    );

    always_comb begin
        state_next = state_reg;
        r1_next    = r1_reg;
        r2_next    = r2_reg;
        d_next     = d_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        x_next     = x_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    r1_next    = R1;
                    r2_next    = R2;
                    state_next = PREP;
                end
            end
            PREP: begin
                d_next     = d_prep;
                acc_next   = '0;
                cnt_next   = CNT_W'(RES_W - 1);
                state_next = MUL;
            end
            MUL: begin
                acc_next = step_acc;
                if (cnt_reg == '0) begin
                    // Result captured once so X stays frozen while DONE waits.
                    x_next     = {step_acc, r2_reg};
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            r1_reg    <= '0;
            r2_reg    <= '0;
            d_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            x_reg     <= '0;
        end else begin
            state_reg <= state_next;
            r1_reg    <= r1_next;
            r2_reg    <= r2_next;
            d_reg     <= d_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            x_reg     <= x_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign X         = x_reg;

endmodule

// File: tb/tb_rns_rev_2011_2048.sv
// ---------------------------------------------------------------------------
// tb_rns_rev_2011_2048
// Directed bench for the {2011, 2048} reverse converter. Expected X values are
// hand-computed CRT results; one line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_rns_rev_2011_2048;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:1] R1        = '0;
    logic [11:1] R2        = '0;
    logic        in_ready;
    logic        out_valid;
    logic [22:1] X;

    int n_cmp = 0;
    int n_bad = 0;

    rns_rev_2011_2048 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .R1        (R1),
        .R2        (R2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic start_op(input logic [10:0] a, input logic [10:0] b);
        @(negedge clk);
        R1       = a;
        R2       = b;
        in_valid = 1'b1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid; bounded at 40.
    task automatic wait_done(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic finish_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [10:0] a, input logic [10:0] b,
                          input logic [31:0] exp_x);
        int e;
        start_op(a, b);
        wait_done(e);
        check({tag, "_latency"}, e, 32'd12);
        check({tag, "_x"}, {10'd0, X}, exp_x);
        $display("op %s: R1=%0d R2=%0d X=%0d (expect %0d) latency=%0d", tag, a, b, X, exp_x, e);
        finish_op(tag);
    endtask

    initial begin
        int e;
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_x", {10'd0, X}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        $display("reset released: in_ready=%0d out_valid=%0d X=%0d", in_ready, out_valid, X);

        // Main function and boundaries
        run_op("zero",       11'd0,    11'd0,    32'd0);
        run_op("r1_37",      11'd37,   11'd0,    32'd2048);
        run_op("r_123456",   11'd785,  11'd576,  32'd123456);
        run_op("max",        11'd2010, 11'd2047, 32'd4118527);
        run_op("r1_noncan",  11'd2011, 11'd5,    32'd2893829);
        run_op("r1_0_r2_5",  11'd0,    11'd5,    32'd2893829);
        run_op("r1_1",       11'd1,    11'd0,    32'd1892352);
        run_op("r2_1",       11'd0,    11'd1,    32'd2226177);
        run_op("r2_noncan",  11'd0,    11'd2011, 32'd2011);

        // Backpressure: hold out_ready low for 20 cycles in DONE
        start_op(11'd37, 11'd0);
        wait_done(e);
        check("hold_latency", e, 32'd12);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (X !== 22'd2048 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("hold_unstable_cycles", bad, 32'd0);
        check("hold_x", {10'd0, X}, 32'd2048);
        $display("op hold: X=%0d after 20 stalled cycles, unstable=%0d", X, bad);
        finish_op("hold");

        // in_valid pulse during MUL must be ignored
        start_op(11'd1, 11'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        R1       = 11'd785;
        R2       = 11'd576;
        in_valid = 1'b1;
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(e);
        check("busy_done_seen", {31'd0, out_valid}, 32'd1);
        check("busy_x", {10'd0, X}, 32'd1892352);
        $display("op busy_pulse: X=%0d (expect 1892352)", X);
        finish_op("busy");
        repeat (15) @(posedge clk);
        #1;
        check("busy_no_second_op", {31'd0, out_valid}, 32'd0);

        // Reset asserted mid-MUL
        start_op(11'd785, 11'd576);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_x", {10'd0, X}, 32'd0);
        $display("op mid_reset: out_valid=%0d X=%0d", out_valid, X);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        run_op("after_rst", 11'd1000, 11'd1000, 32'd1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
